// File: rtl/alu_ctrl.sv
// Instruction sequencer for the 8-bit ALU datapath: decodes byte-oriented
// instructions, drives the ALU selects/operands, and owns W and the C/DC/Z flags.
module alu_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [13:0] instr,
  input  logic        instr_valid,
  output logic        instr_ready,
  output logic        done,
  output logic        illegal,
  output logic [6:0]  rf_raddr,
  output logic        rf_rd,
  input  logic [7:0]  rf_rdata,
  output logic        rf_we,
  output logic [6:0]  rf_waddr,
  output logic [7:0]  rf_wdata,
  output logic        clr,
  output logic        swap_n_mov,
  output logic        rlf_n_rrf,
  output logic        sub,
  output logic [1:0]  op_mux_l,
  output logic [1:0]  op_mux_a,
  output logic [1:0]  out_mux,
  output logic        C_in,
  output logic [7:0]  op_A1,
  output logic [7:0]  op_A,
  output logic [7:0]  op_B,
  input  logic [7:0]  alu_out,
  input  logic        C_new,
  input  logic        DC_new,
  input  logic        Z_new,
  output logic [7:0]  w_out,
  output logic        status_c,
  output logic        status_dc,
  output logic        status_z
);

  typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, EXEC = 2'd2, WB = 2'd3} state_t;

  state_t      state_r, state_next_s;
  logic [13:0] instr_r, cur_instr_s;
  logic [3:0]  opcode_s;
  logic        d_s, accept_s;

  logic        dec_illegal_s, dec_reads_f_s, dec_writes_s, dec_a1_w_s;
  logic        dec_upd_c_s, dec_upd_dc_s, dec_upd_z_s;
  logic        dec_clr_s, dec_swap_s, dec_rlf_s, dec_sub_s;
  logic [1:0]  dec_out_mux_s, dec_mux_a_s, dec_mux_l_s;

  logic        rf_rd_r, rf_we_r, done_r, illegal_r, exec_rd_r;
  logic        clr_r, swap_r, rlf_r, sub_r;
  logic [1:0]  out_mux_r, mux_a_r, mux_l_r;
  logic [7:0]  op_a1_r, op_b_r, res_r, w_r;
  logic        c_cap_r, dc_cap_r, z_cap_r, c_r, dc_r, z_r;

  assign instr_ready = (state_r == IDLE) && !rst;
  assign accept_s    = instr_valid && instr_ready;
  // In IDLE the decoder looks at the word being offered so READ-cycle strobes can be registered.
  assign cur_instr_s = (state_r == IDLE) ? instr : instr_r;
  assign opcode_s    = cur_instr_s[11:8];
  assign d_s         = cur_instr_s[7];

  // Instruction decode into ALU controls, operand source and flag-update mask.
  always_comb begin
    dec_illegal_s = 1'b0;
    dec_reads_f_s = 1'b0;
    dec_writes_s  = 1'b1;
    dec_a1_w_s    = 1'b0;
    dec_upd_c_s   = 1'b0;
    dec_upd_dc_s  = 1'b0;
    dec_upd_z_s   = 1'b0;
    dec_clr_s     = 1'b0;
    dec_swap_s    = 1'b0;
    dec_rlf_s     = 1'b0;
    dec_sub_s     = 1'b0;
    dec_out_mux_s = 2'd0;
    dec_mux_a_s   = 2'd0;
    dec_mux_l_s   = 2'd0;
    if (cur_instr_s[13:12] != 2'b00) begin
      dec_illegal_s = 1'b1;
      dec_writes_s  = 1'b0;
    end else begin
      case (opcode_s)
        4'b0111: begin dec_out_mux_s = 2'd3; dec_reads_f_s = 1'b1;
                       dec_upd_c_s = 1'b1; dec_upd_dc_s = 1'b1; dec_upd_z_s = 1'b1; end
        4'b0010: begin dec_out_mux_s = 2'd3; dec_mux_a_s = 2'd1; dec_sub_s = 1'b1; dec_reads_f_s = 1'b1;
                       dec_upd_c_s = 1'b1; dec_upd_dc_s = 1'b1; dec_upd_z_s = 1'b1; end
        4'b1010: begin dec_out_mux_s = 2'd3; dec_mux_a_s = 2'd2; dec_reads_f_s = 1'b1; dec_upd_z_s = 1'b1; end
        4'b0011: begin dec_out_mux_s = 2'd3; dec_mux_a_s = 2'd3; dec_reads_f_s = 1'b1; dec_upd_z_s = 1'b1; end
        4'b0100: begin dec_out_mux_s = 2'd2; dec_mux_l_s = 2'd0; dec_reads_f_s = 1'b1; dec_upd_z_s = 1'b1; end
        4'b0101: begin dec_out_mux_s = 2'd2; dec_mux_l_s = 2'd1; dec_reads_f_s = 1'b1; dec_upd_z_s = 1'b1; end
        4'b0110: begin dec_out_mux_s = 2'd2; dec_mux_l_s = 2'd2; dec_reads_f_s = 1'b1; dec_upd_z_s = 1'b1; end
        4'b1001: begin dec_out_mux_s = 2'd2; dec_mux_l_s = 2'd3; dec_reads_f_s = 1'b1; dec_upd_z_s = 1'b1; end
        4'b1101: begin dec_out_mux_s = 2'd1; dec_rlf_s = 1'b1; dec_reads_f_s = 1'b1; dec_upd_c_s = 1'b1; end
        4'b1100: begin dec_out_mux_s = 2'd1; dec_reads_f_s = 1'b1; dec_upd_c_s = 1'b1; end
        4'b1110: begin dec_swap_s = 1'b1; dec_reads_f_s = 1'b1; end
        4'b1000: begin dec_reads_f_s = 1'b1; dec_upd_z_s = 1'b1; end
        4'b0001: begin dec_clr_s = 1'b1; dec_upd_z_s = 1'b1; end
        4'b0000: begin
          if (d_s) begin
            dec_a1_w_s = 1'b1;
          end else begin
            dec_writes_s = 1'b0;
          end
        end
        default: begin dec_illegal_s = 1'b1; dec_writes_s = 1'b0; end
      endcase
    end
  end

  // Next-state logic: fixed four-cycle walk once an instruction is accepted.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_next_s = READ;
        end else begin
          state_next_s = IDLE;
        end
      end
      READ:    state_next_s = EXEC;
      EXEC:    state_next_s = WB;
      WB:      state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // State register and instruction latch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      instr_r <= 14'h0000;
    end else begin
      state_r <= state_next_s;
      if (accept_s) begin
        instr_r <= instr;
      end
    end
  end

  // Registered strobes and ALU controls, loaded on entry to the state that uses them.
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_rd_r   <= 1'b0;
      rf_we_r   <= 1'b0;
      done_r    <= 1'b0;
      illegal_r <= 1'b0;
      exec_rd_r <= 1'b0;
      clr_r     <= 1'b0;
      swap_r    <= 1'b0;
      rlf_r     <= 1'b0;
      sub_r     <= 1'b0;
      out_mux_r <= 2'd0;
      mux_a_r   <= 2'd0;
      mux_l_r   <= 2'd0;
      op_a1_r   <= 8'h00;
      op_b_r    <= 8'h00;
    end else begin
      rf_rd_r   <= (state_next_s == READ) && dec_reads_f_s;
      rf_we_r   <= (state_next_s == WB) && dec_writes_s && d_s;
      done_r    <= (state_next_s == WB);
      illegal_r <= (state_next_s == WB) && dec_illegal_s;
      if (state_next_s == EXEC) begin
        exec_rd_r <= dec_reads_f_s;
        clr_r     <= dec_clr_s;
        swap_r    <= dec_swap_s;
        rlf_r     <= dec_rlf_s;
        sub_r     <= dec_sub_s;
        out_mux_r <= dec_out_mux_s;
        mux_a_r   <= dec_mux_a_s;
        mux_l_r   <= dec_mux_l_s;
        op_a1_r   <= dec_a1_w_s ? w_r : 8'h00;
        op_b_r    <= w_r;
      end else begin
        exec_rd_r <= 1'b0;
        clr_r     <= 1'b0;
        swap_r    <= 1'b0;
        rlf_r     <= 1'b0;
        sub_r     <= 1'b0;
        out_mux_r <= 2'd0;
        mux_a_r   <= 2'd0;
        mux_l_r   <= 2'd0;
        op_a1_r   <= 8'h00;
        op_b_r    <= 8'h00;
      end
    end
  end

  // Result capture in EXEC; W and flag commit at the WB->IDLE edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_r    <= 8'h00;
      c_cap_r  <= 1'b0;
      dc_cap_r <= 1'b0;
      z_cap_r  <= 1'b0;
      w_r      <= 8'h00;
      c_r      <= 1'b0;
      dc_r     <= 1'b0;
      z_r      <= 1'b0;
    end else begin
      if (state_r == EXEC) begin
        res_r    <= alu_out;
        c_cap_r  <= C_new;
        dc_cap_r <= DC_new;
        z_cap_r  <= Z_new;
      end
      if ((state_r == WB) && !dec_illegal_s) begin
        if (dec_writes_s && !d_s) w_r <= res_r;
        if (dec_upd_c_s)  c_r  <= c_cap_r;
        if (dec_upd_dc_s) dc_r <= dc_cap_r;
        if (dec_upd_z_s)  z_r  <= z_cap_r;
      end
    end
  end

  // File data arrives combinationally in EXEC, so the f operands bypass the registers.
  assign op_A       = exec_rd_r ? rf_rdata : 8'h00;
  assign op_A1      = exec_rd_r ? rf_rdata : op_a1_r;
  assign op_B       = op_b_r;
  assign rf_rd      = rf_rd_r;
  assign rf_we      = rf_we_r;
  assign done       = done_r;
  assign illegal    = illegal_r;
  assign rf_raddr   = instr_r[6:0];
  assign rf_waddr   = instr_r[6:0];
  assign rf_wdata   = res_r;
  assign clr        = clr_r;
  assign swap_n_mov = swap_r;
  assign rlf_n_rrf  = rlf_r;
  assign sub        = sub_r;
  assign out_mux    = out_mux_r;
  assign op_mux_a   = mux_a_r;
  assign op_mux_l   = mux_l_r;
  assign C_in       = c_r;
  assign w_out      = w_r;
  assign status_c   = c_r;
  assign status_dc  = dc_r;
  assign status_z   = z_r;

endmodule

// File: tb/tb_alu_ctrl.sv
// Self-checking bench for alu_ctrl: behavioural ALU + register file around the DUT,
// directed scenarios and random instructions checked against an arithmetic reference model.
module tb_alu_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [13:0] instr;
  logic        instr_valid, instr_ready, done, illegal;
  logic [6:0]  rf_raddr, rf_waddr;
  logic        rf_rd, rf_we;
  logic [7:0]  rf_rdata, rf_wdata;
  logic        clr, swap_n_mov, rlf_n_rrf, sub, C_in;
  logic [1:0]  op_mux_l, op_mux_a, out_mux;
  logic [7:0]  op_A1, op_A, op_B, alu_out, w_out;
  logic        C_new, DC_new, Z_new, status_c, status_dc, status_z;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [7:0]  mem [128];
  logic [7:0]  w_m;
  logic        c_m, dc_m, z_m;
  logic [8:0]  add_s;
  logic [4:0]  half_s;
  logic [7:0]  b_s;

  alu_ctrl dut (
    .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .done(done), .illegal(illegal), .rf_raddr(rf_raddr), .rf_rd(rf_rd), .rf_rdata(rf_rdata),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .clr(clr), .swap_n_mov(swap_n_mov),
    .rlf_n_rrf(rlf_n_rrf), .sub(sub), .op_mux_l(op_mux_l), .op_mux_a(op_mux_a), .out_mux(out_mux),
    .C_in(C_in), .op_A1(op_A1), .op_A(op_A), .op_B(op_B), .alu_out(alu_out), .C_new(C_new),
    .DC_new(DC_new), .Z_new(Z_new), .w_out(w_out), .status_c(status_c), .status_dc(status_dc),
    .status_z(status_z)
  );

  always #5 clk = ~clk;

  // Register file read port: data valid the cycle after the strobe, junk otherwise.
  always @(posedge clk) rf_rdata <= rf_rd ? mem[rf_raddr] : 8'($urandom);

  // Behavioural ALU driven by the controller's selects.
  always_comb begin
    alu_out = 8'h00; C_new = 1'b0; DC_new = 1'b0;
    add_s = 9'h000; half_s = 5'h00; b_s = 8'h00;
    case (out_mux)
      2'd0: alu_out = clr ? 8'h00 : (swap_n_mov ? {op_A1[3:0], op_A1[7:4]} : op_A1);
      2'd1: begin
        if (rlf_n_rrf) begin alu_out = {op_A[6:0], C_in}; C_new = op_A[7]; end
        else begin alu_out = {C_in, op_A[7:1]}; C_new = op_A[0]; end
      end
      2'd2: begin
        case (op_mux_l)
          2'd0: alu_out = op_A | op_B;
          2'd1: alu_out = op_A & op_B;
          2'd2: alu_out = op_A ^ op_B;
          default: alu_out = ~op_A;
        endcase
      end
      default: begin
        case (op_mux_a)
          2'd2: b_s = 8'h01;
          2'd3: b_s = 8'hFF;
          default: b_s = sub ? ~op_B : op_B;
        endcase
        add_s  = {1'b0, op_A} + {1'b0, b_s} + {8'h00, sub};
        half_s = {1'b0, op_A[3:0]} + {1'b0, b_s[3:0]} + {4'h0, sub};
        alu_out = add_s[7:0]; C_new = add_s[8]; DC_new = half_s[4];
      end
    endcase
    Z_new = (alu_out == 8'h00);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: instruction semantics in plain integer arithmetic.
  task automatic model_step(input logic [13:0] ins, input logic [7:0] f,
                            output logic ill, output logic we, output logic [7:0] res);
    int fv, wv, r;
    bit wr, uz;
    fv = int'(f); wv = int'(w_m); r = 0; wr = 1'b1; uz = 1'b0; ill = 1'b0;
    if (ins[13:12] != 2'b00) begin
      ill = 1'b1; wr = 1'b0;
    end else begin
      case (ins[11:8])
        4'h7: begin r = fv + wv; c_m = (r > 255); dc_m = ((fv % 16) + (wv % 16) > 15); uz = 1'b1; end
        4'h2: begin r = fv - wv + 256; c_m = (fv >= wv); dc_m = ((fv % 16) >= (wv % 16)); uz = 1'b1; end
        4'hA: begin r = fv + 1; uz = 1'b1; end
        4'h3: begin r = fv + 255; uz = 1'b1; end
        4'h4: begin r = fv | wv; uz = 1'b1; end
        4'h5: begin r = fv & wv; uz = 1'b1; end
        4'h6: begin r = fv ^ wv; uz = 1'b1; end
        4'h9: begin r = 255 - fv; uz = 1'b1; end
        4'hD: begin r = fv * 2 + (c_m ? 1 : 0); c_m = (fv >= 128); end
        4'hC: begin r = fv / 2 + (c_m ? 128 : 0); c_m = ((fv % 2) == 1); end
        4'hE: r = (fv % 16) * 16 + fv / 16;
        4'h8: begin r = fv; uz = 1'b1; end
        4'h1: begin r = 0; uz = 1'b1; end
        4'h0: begin
          if (ins[7]) r = wv;
          else wr = 1'b0;
        end
        default: begin ill = 1'b1; wr = 1'b0; end
      endcase
    end
    r = r % 256;
    if (uz) z_m = (r == 0);
    res = 8'(r);
    we  = wr && ins[7];
    if (wr && !ins[7]) w_m = 8'(r);
  endtask

  // Issue one instruction (caller is at a negedge in IDLE) and check it through to commit.
  task automatic run_instr(input logic [13:0] ins);
    logic [7:0] res;
    logic       ill, we;
    bit         seen;
    model_step(ins, mem[ins[6:0]], ill, we, res);
    instr = ins; instr_valid = 1'b1;
    check_eq("ready", instr_ready, 1);
    seen = 1'b0;
    for (int cyc = 1; cyc <= 8 && !seen; cyc++) begin
      @(negedge clk);
      instr = 14'($urandom); instr_valid = 1'($urandom);
      if (done) begin
        seen = 1'b1;
        check_eq("latency", cyc, 3);
        check_eq("illegal", illegal, ill);
        check_eq("rf_we", rf_we, we);
        if (we) begin
          check_eq("rf_waddr", rf_waddr, ins[6:0]);
          check_eq("rf_wdata", rf_wdata, res);
          mem[rf_waddr] = rf_wdata;
        end
      end else begin
        check_eq("rf_we_busy", rf_we, 0);
        check_eq("illegal_busy", illegal, 0);
      end
    end
    if (!seen) check_eq("done_timeout", done, 1);
    instr_valid = 1'b0;
    @(negedge clk);
    check_eq("w", w_out, w_m);
    check_eq("status_c", status_c, c_m);
    check_eq("status_dc", status_dc, dc_m);
    check_eq("status_z", status_z, z_m);
  endtask

  initial begin
    foreach (mem[i]) mem[i] = 8'($urandom);
    rst = 1'b1; instr = 14'h0000; instr_valid = 1'b0;
    w_m = 8'h00; c_m = 1'b0; dc_m = 1'b0; z_m = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_ready", instr_ready, 0);
    check_eq("rst_w", w_out, 0);
    check_eq("rst_flags", {status_c, status_dc, status_z}, 0);
    check_eq("rst_strobes", {rf_rd, rf_we, done, illegal}, 0);
    check_eq("rst_ctrl", {clr, swap_n_mov, rlf_n_rrf, sub, op_mux_l, op_mux_a, out_mux}, 0);
    check_eq("rst_ops", {op_A1, op_A, op_B}, 0);
    rst = 1'b0;
    @(negedge clk);

    mem[7'h20] = 8'h0F; run_instr(14'h0820);            // MOVF 0x20,W -> W=0x0F
    mem[7'h20] = 8'h01; run_instr(14'h07A0);            // ADDWF 0x20,f
    check_eq("add_result", mem[7'h20], 8'h10);
    check_eq("add_dc", status_dc, 1);
    mem[7'h21] = 8'h05; run_instr(14'h0821);
    run_instr(14'h0221);                                // SUBWF 0x21,W
    check_eq("sub_flags", {w_out, status_c, status_dc, status_z}, 11'h007);
    mem[7'h22] = 8'h80; run_instr(14'h0DA2);            // RLF 0x22,f
    check_eq("rlf_result", mem[7'h22], 8'h01);
    mem[7'h23] = 8'h3C; run_instr(14'h0823);
    mem[7'h24] = 8'hA5; run_instr(14'h0E24);            // SWAPF 0x24,W
    run_instr(14'h00B0);                                // MOVWF 0x30
    check_eq("movwf_result", mem[7'h30], 8'h5A);
    run_instr(14'h3000);
    run_instr(14'h0B20);

    // Reset in the EXEC cycle of ADDWF 0x20,f aborts it.
    mem[7'h20] = 8'h33;
    instr = 14'h07A0; instr_valid = 1'b1;
    @(negedge clk); instr_valid = 1'b0;
    @(negedge clk); rst = 1'b1;
    check_eq("abort_ready", instr_ready, 0);
    @(negedge clk);
    check_eq("abort_strobes", {rf_we, done, illegal}, 0);
    check_eq("abort_w", w_out, 0);
    check_eq("abort_flags", {status_c, status_dc, status_z}, 0);
    @(negedge clk); rst = 1'b0;
    w_m = 8'h00; c_m = 1'b0; dc_m = 1'b0; z_m = 1'b0;
    @(negedge clk);
    check_eq("post_rst_ready", instr_ready, 1);
    check_eq("abort_mem", mem[7'h20], 8'h33);
    run_instr(14'h0100);                                // CLRW
    check_eq("clrw_z", status_z, 1);

    for (int n = 0; n < 300; n++) begin
      logic [13:0] ins;
      ins = 14'($urandom);
      if ($urandom_range(0, 7) != 0) ins[13:12] = 2'b00;
      run_instr(ins);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed hang expected finish");
    $fatal(1);
  end

endmodule

// File: doc/alu_ctrl.md
# alu_ctrl

Sequencer for the 8-bit ALU datapath. It accepts one 14-bit byte-oriented instruction at a time, reads the file-register operand, and drives every ALU select and operand input. It then captures ALU_out/C_new/DC_new/Z_new and writes the result back to W or the file register, updating the C/DC/Z status bits. It sits between the fetch stage and the ALU/register file; it owns the W and STATUS flag registers.

## Interface
- No parameters; data width fixed at 8, file address 7, instruction 14.
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- instr  in  14  instruction word, sampled on accept
- instr_valid  in  1  instruction offered
- instr_ready  out  1  high only in IDLE and rst low
- done  out  1  one-cycle pulse in WB
- illegal  out  1  one-cycle pulse with done for unsupported opcode
- rf_raddr  out  7  instr[6:0], held from READ through WB
- rf_rd  out  1  read strobe in READ (only when op reads f)
- rf_rdata  in  8  file data, valid the cycle after rf_rd
- rf_we  out  1  write strobe in WB when d=1 and op writes
- rf_waddr  out  7  = rf_raddr
- rf_wdata  out  8  captured ALU result
- clr, swap_n_mov, rlf_n_rrf, sub  out  1 each  ALU controls
- op_mux_l, op_mux_a, out_mux  out  2 each  ALU selects (out_mux 0 through, 1 shift, 2 logic, 3 adder)
- C_in  out  1  = status_c
- op_A1, op_A, op_B  out  8 each  ALU operands
- alu_out  in  8; C_new, DC_new, Z_new  in  1 each  ALU results
- w_out  out  8  W register
- status_c, status_dc, status_z  out  1 each  flag registers

## Operation
- FSM: IDLE -> READ -> EXEC -> WB -> IDLE; no stalls.
- IDLE: accept when instr_valid & instr_ready; latch instr.
- READ: assert rf_rd if op reads f.
- EXEC: op_A = op_A1 = rf_rdata, op_B = W; drive controls; capture alu_out, C_new, DC_new, Z_new at clock edge.
- WB: d=1 -> rf_we; d=0 -> W <= result at edge; update only the flags listed; pulse done.
- Decode (instr[13:12] must be 00; opcode = instr[11:8], d = instr[7]):
  - 0111 ADDWF: adder, op_mux_a=0, sub=0; C, DC, Z
  - 0010 SUBWF: adder, op_mux_a=1, sub=1 (f - W); C (1 = no borrow), DC, Z
  - 1010 INCF / 0011 DECF: adder, op_mux_a=2/3; Z
  - 0100 IORWF / 0101 ANDWF / 0110 XORWF / 1001 COMF: logic, op_mux_l=0/1/2/3; Z
  - 1101 RLF / 1100 RRF: shift, rlf_n_rrf=1/0; C
  - 1110 SWAPF: through, swap_n_mov=1; no flags
  - 1000 MOVF: through, swap_n_mov=0; Z
  - 0001 CLRF (d=1) / CLRW (d=0): through, clr=1; Z (set to 1); no f read
  - 0000 d=1 MOVWF: through, op_A1 = W, writes f; no flags; no f read
  - 0000 d=0 NOP: no write, no flags
  - 1011, 1111, or instr[13:12] != 00: illegal; no write, no flag change; done and illegal pulse in WB
- Controls not used by the selected op are held at 0.

## Timing
- Accept at edge k: READ at k+1, EXEC at k+2, WB at k+3, IDLE at k+4.
- Latency is 3 cycles, accept to done; throughput is 1 instruction per 4 cycles.
- rf_we, done, and illegal are asserted only during the WB cycle. W and flags change at the WB->IDLE edge.
- A back-to-back instruction sees the updated W and flags; there is no hazard.
- Reset values: state IDLE, W=0x00, status_c/dc/z=0, rf_rd=rf_we=done=illegal=0, all ALU controls and operands 0, instr_ready=0 while rst is high.
- Reset in any state aborts the instruction with no rf_we and no further W/flag update. instr_ready=1 in the first cycle after rst falls.
- instr_valid outside IDLE is ignored; instr may change freely after accept.

## Test plan
- W=0x0F, f[0x20]=0x01, ADDWF 0x20,d=1 -> WB: rf_we=1, rf_waddr=0x20, rf_wdata=0x10; C=0, DC=1, Z=0; done at accept+3.
- W=0x05, f=0x05, SUBWF d=0 -> W=0x00; Z=1, C=1, DC=1; rf_we=0.
- C=1, f=0x80, RLF d=1 -> rf_wdata=0x01, C=1; Z unchanged from prior value.
- W=0x3C, f=0xA5, SWAPF d=0 then MOVWF 0x30 -> W=0x5A; f[0x30] write 0x5A; all flags unchanged both instructions.
- instr=0x3000 then instr=0x0B20 (DECFSZ) -> illegal and done pulse each; no rf_we; W and flags unchanged.
- Assert rst during EXEC of ADDWF d=1 -> no rf_we; W=0 and flags=0 after reset; instr_ready=1 one cycle after rst drops; a following CLRW sets Z=1.
